// File: rtl/if_id_buf_pkg.sv
// -----------------------------------------------------------------------------
// if_id_buf_pkg
// Shared definitions for the IF/ID instruction buffer: the bus widths, the
// zero word that idle outputs present, and the {pc, inst} entry type held in
// the buffer.
// -----------------------------------------------------------------------------
package if_id_buf_pkg;

    // Instruction address bus and instruction bus widths.
    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    // Value presented on the data outputs when no entry is valid.
    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    // One buffered fetch result.
    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } entry_t;

endpackage : if_id_buf_pkg

// File: rtl/if_id_buf.sv
// -----------------------------------------------------------------------------
// if_id_buf
// First-word-fall-through FIFO of {pc, inst} pairs between the fetch stage
// and the decode stage.  A flush (branch/jump redirect) discards every
// buffered entry.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-low reset
//   in_valid_i   : fetch presents a valid pc/instruction pair
//   in_pc_i      : pc of the fetched instruction
//   in_inst_i    : fetched instruction word
//   in_ready_o   : buffer can accept an entry this cycle (not full)
//   flush_i      : discard all buffered entries, ignore this cycle's push/pop
//   out_valid_o  : head entry is valid for decode (not empty)
//   out_pc_o     : pc of the head entry, zero when out_valid_o is low
//   out_inst_o   : instruction of the head entry, zero when out_valid_o is low
//   out_ready_i  : decode consumes the head entry this cycle
//   count_o      : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int DEPTH = 4   // legal values: 2, 4, 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    input  logic [INST_ADDR_W-1:0]     in_pc_i,
    input  logic [INST_W-1:0]          in_inst_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    output logic [INST_ADDR_W-1:0]     out_pc_o,
    output logic [INST_W-1:0]          out_inst_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    // Storage and pointers.  DEPTH is a power of two, so pointers wrap
    // modulo DEPTH through plain overflow of their AW bits.
    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [AW:0]     r_count;

    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_push;
    logic            w_pop;
    entry_t          w_head_entry;

    // Ready/valid come from the registered count only, so there is no
    // combinational path from out_ready_i to in_ready_o: a full buffer
    // refuses a push even while decode is popping.
    assign w_in_ready  = (r_count != CNT_FULL);
    assign w_out_valid = (r_count != '0);

    // Popping only when already non-empty means a push into an empty
    // buffer is never bypassed to the output in the same cycle.
    assign w_push = in_valid_i  && w_in_ready  && !flush_i;
    assign w_pop  = w_out_valid && out_ready_i && !flush_i;

    // Pointer and occupancy state.  Reset outranks flush, flush outranks
    // push/pop.
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples values from before the edge, whatever the block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            // Simultaneous push and pop leaves the count unchanged.
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone decide
    // which entries are live, so stale contents are never observed and the
    // array can map onto plain registers or RAM without a reset network.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{pc: in_pc_i, inst: in_inst_i};
        end
    end

    // First-word fall-through: the head entry drives the outputs directly.
    assign w_head_entry = r_mem[r_head];

    // NOTE: every output of this always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        out_pc_o   = ZERO_WORD;
        out_inst_o = ZERO_WORD;
        if (w_out_valid) begin
            out_pc_o   = w_head_entry.pc;
            out_inst_o = w_head_entry.inst;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign count_o     = r_count;

endmodule : if_id_buf

// File: doc/if_id_buf.md
IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction entries; legal values 2, 4, 8 (power of two).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-low (state clears on the rising clk edge while rst==0).
REQ-004 SHALL have port in_valid_i  input  1  fetch stage presents a valid pc/instruction pair.
REQ-005 SHALL have port in_pc_i  input  32  pc of the fetched instruction.
REQ-006 SHALL have port in_inst_i  input  32  fetched instruction word.
REQ-007 SHALL have port in_ready_o  output  1  buffer can accept an entry this cycle.
REQ-008 SHALL have port flush_i  input  1  branch/jump redirect; discard all buffered entries.
REQ-009 SHALL have port out_valid_o  output  1  head entry is valid for decode.
REQ-010 SHALL have port out_pc_o  output  32  pc of the head entry.
REQ-011 SHALL have port out_inst_o  output  32  instruction of the head entry.
REQ-012 SHALL have port out_ready_i  input  1  decode consumes the head entry this cycle (low = decode stall).
REQ-013 SHALL have port count_o  output  log2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL operate as a FIFO of {pc, inst} pairs with first-word fall-through: out_* reflect the head entry combinationally from storage.
REQ-015 SHALL perform a push when in_valid_i && in_ready_o && !flush_i, writing at tail and advancing tail by 1.
REQ-016 SHALL perform a pop when out_valid_o && out_ready_i && !flush_i, advancing head by 1.
REQ-017 SHALL drive in_ready_o = (count_o != DEPTH), depending only on registered state (no combinational path from out_ready_i).
REQ-018 SHALL drive out_valid_o = (count_o != 0).
REQ-019 SHALL drive out_pc_o and out_inst_o to 32'h0 whenever out_valid_o==0.
REQ-020 SHALL give a push-to-visible latency of exactly 1 cycle: an entry pushed at edge N is on out_* after edge N.
REQ-021 SHALL update count on simultaneous push and pop so it stays unchanged, and SHALL place both head and tail correctly.
REQ-022 SHALL, when empty, not pop in the same cycle as a push (no bypass); the pushed entry appears next cycle.
REQ-023 SHALL, when full, deassert in_ready_o even if out_ready_i is high; a pop that cycle re-enables in_ready_o next cycle.
REQ-024 SHALL wrap head and tail modulo DEPTH.
REQ-025 SHALL, when flush_i==1 at an edge, set head=tail=0 and count=0, discarding any push or pop presented that cycle.
REQ-026 SHALL preserve entry order exactly; no entry is duplicated or dropped except by flush or reset.
REQ-027 SHALL leave storage contents unspecified after flush; only pointers and count are cleared.

Reset
REQ-028 SHALL, when rst==0 at a rising clk edge, clear head, tail, and count to 0, giving out_valid_o=0, in_ready_o=1, out_pc_o=out_inst_o=32'h0.
REQ-029 SHALL give reset priority over flush, push, and pop, including reset asserted mid-stream with the buffer partially full.
REQ-030 SHALL NOT require storage array contents to be reset.

Structure
REQ-031 SHALL take the 32-bit bus widths (InstAddrBus, InstBus) and ZeroWord from the shared Defines.vh; DEPTH stays a local parameter.
REQ-032 SHALL keep storage, pointers, and count inline; no sub-module is required.

Verification
REQ-033 Bench SHALL cover reset: rst=0 for 2 cycles with in_valid_i=1 -> count_o=0, out_valid_o=0, in_ready_o=1, out_inst_o=0.
REQ-034 Bench SHALL cover fill to full: push pc 0x0,0x4,0x8,0xC with out_ready_i=0 -> count_o=4, in_ready_o=0, out_pc_o=0x0; a fifth push is ignored.
REQ-035 Bench SHALL cover drain: with the buffer full, out_ready_i=1 for 4 cycles -> out_pc_o sequence 0x0,0x4,0x8,0xC, then out_valid_o=0.
REQ-036 Bench SHALL cover streaming: continuous push and pop with count_o=2 for 20 cycles -> count_o constant at 2, pcs in order, wrap crossed at least twice.
REQ-037 Bench SHALL cover flush: at count_o=3, assert flush_i with in_valid_i=1 (pc 0x100) -> next cycle count_o=0, out_valid_o=0, and 0x100 is not stored.
REQ-038 Bench SHALL cover reset mid-operation: count_o=2 and rst=0 for one edge with a push and pop pending -> count_o=0; a push afterwards of pc 0x200 appears at the head 1 cycle later.
